cla_nibble_serial_adder: RTL and testbench

Multi-cycle controller that time-shares one combinational 4-bit augmented CLA slice (sum, p, g) to add two W-bit operands, one nibble per clock, LSB nibble first. It sequences the slice, chains carry between nibbles, and accumulates block-level propagate/generate. It uses a start/ready/done handshake. It sits beside the existing 4-bit CLA wrapper as an area-saving adder for wide operands.

---
 rtl/cla_nibble_serial_adder.sv | 172 +++++++++++++++++
 tb/tb_cla_nibble_serial_adder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/cla_nibble_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : cla_nibble_serial_adder
// Description : Multi-cycle W-bit adder (W = 4*NIBBLES) that reuses a single
//               4-bit carry-lookahead slice once per clock, LSB nibble first.
//               Chains carry between nibbles and accumulates the block-level
//               propagate/generate. start/ready/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module cla_nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   in1,
  input  logic [4*NIBBLES-1:0]   in2,
  input  logic                   cin,
  output logic                   ready,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   cout,
  output logic                   p,
  output logic                   g,
  output logic                   ovf
);

  localparam int c_W  = 4 * NIBBLES;
  localparam int c_IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [c_IW-1:0] c_LAST = c_IW'(NIBBLES - 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  logic [1:0]      r_state;
  logic [1:0]      w_next_state;
  logic            w_ready;
  logic            w_done;
  logic            w_accept;

  logic [c_W-1:0]  r_a;
  logic [c_W-1:0]  r_b;
  logic            r_carry;
  logic [c_IW-1:0] r_idx;
  logic            r_pacc;
  logic            r_gacc;
  logic [c_W-1:0]  r_sum;
  logic            r_cout;
  logic            r_p;
  logic            r_g;
  logic            r_ovf;

  // Shared slice signals
  logic [3:0]      w_a_nib;
  logic [3:0]      w_b_nib;
  logic [3:0]      w_bp;
  logic [3:0]      w_bg;
  logic [3:0]      w_c;
  logic [3:0]      w_ns;
  logic            w_np;
  logic            w_ng;
  logic            w_nc;
  logic            w_pacc_nxt;
  logic            w_gacc_nxt;
  logic [c_IW+1:0] w_base;

  assign w_base  = {r_idx, 2'b00};
  assign w_a_nib = r_a[w_base +: 4];
  assign w_b_nib = r_b[w_base +: 4];

  // 4-bit lookahead slice: bit carries, nibble sum, nibble propagate/generate
  always_comb begin
    w_bp = w_a_nib ^ w_b_nib;
    w_bg = w_a_nib & w_b_nib;
    w_c[0] = r_carry;
    w_c[1] = w_bg[0] | (w_bp[0] & r_carry);
    w_c[2] = w_bg[1] | (w_bp[1] & w_bg[0]) | (w_bp[1] & w_bp[0] & r_carry);
    w_c[3] = w_bg[2] | (w_bp[2] & w_bg[1]) | (w_bp[2] & w_bp[1] & w_bg[0])
           | (w_bp[2] & w_bp[1] & w_bp[0] & r_carry);
    w_ns = w_bp ^ w_c;
    w_np = &w_bp;
    w_ng = w_bg[3] | (w_bp[3] & w_bg[2]) | (w_bp[3] & w_bp[2] & w_bg[1])
         | (w_bp[3] & w_bp[2] & w_bp[1] & w_bg[0]);
    w_nc = w_ng | (w_np & r_carry);
    w_pacc_nxt = r_pacc & w_np;
    w_gacc_nxt = w_ng | (w_np & r_gacc);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= c_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE:  if (start) w_next_state = c_RUN;
      c_RUN:   if (r_idx == c_LAST) w_next_state = c_DONE;
      c_DONE:  w_next_state = start ? c_RUN : c_IDLE;
      default: w_next_state = c_IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    w_ready = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      c_IDLE:  w_ready = 1'b1;
      c_DONE:  begin w_ready = 1'b1; w_done = 1'b1; end
      default: begin w_ready = 1'b0; w_done = 1'b0; end
    endcase
  end

  assign w_accept = w_ready & start;

  // Datapath: operand capture, per-nibble accumulation, final flag capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_pacc  <= 1'b0;
      r_gacc  <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_p     <= 1'b0;
      r_g     <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= in1;
      r_b     <= in2;
      r_carry <= cin;
      r_idx   <= '0;
      r_pacc  <= 1'b1;
      r_gacc  <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_p     <= 1'b0;
      r_g     <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (r_state == c_RUN) begin
      r_sum[w_base +: 4] <= w_ns;
      r_carry <= w_nc;
      r_pacc  <= w_pacc_nxt;
      r_gacc  <= w_gacc_nxt;
      if (r_idx == c_LAST) begin
        // Index parks on the last nibble; flags come from this final slice
        r_cout <= w_nc;
        r_p    <= w_pacc_nxt;
        r_g    <= w_gacc_nxt;
        r_ovf  <= (r_a[c_W-1] == r_b[c_W-1]) && (w_ns[3] != r_a[c_W-1]);
      end else begin
        r_idx <= r_idx + c_IW'(1);
      end
    end
  end

  assign ready = w_ready;
  assign done  = w_done;
  assign sum   = r_sum;
  assign cout  = r_cout;
  assign p     = r_p;
  assign g     = r_g;
  assign ovf   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_cla_nibble_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_cla_nibble_serial_adder
// Description : Scoreboard bench for cla_nibble_serial_adder (NIBBLES=4 and
//               NIBBLES=2 instances), directed vectors with hand-computed
//               results and done-cycle expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cla_nibble_serial_adder;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        p;
    logic        g;
    logic        ovf;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start,  cin;
  logic [15:0] in1, in2;
  logic        ready, done, cout, p, g, ovf;
  logic [15:0] sum;

  logic        start2, cin2;
  logic [7:0]  in1_2, in2_2;
  logic        ready2, done2, cout2, p2, g2, ovf2;
  logic [7:0]  sum2;

  exp_t q[$];
  exp_t q2[$];
  exp_t me;
  exp_t me2;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  cla_nibble_serial_adder #(.NIBBLES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .in1(in1), .in2(in2), .cin(cin),
    .ready(ready), .done(done), .sum(sum), .cout(cout), .p(p), .g(g), .ovf(ovf)
  );

  cla_nibble_serial_adder #(.NIBBLES(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .in1(in1_2), .in2(in2_2), .cin(cin2),
    .ready(ready2), .done(done2), .sum(sum2), .cout(cout2), .p(p2), .g(g2), .ovf(ovf2)
  );

  always #5 clk = ~clk;

  // Edge counter: at a negedge, cyc equals the number of the last posedge
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor for the 16-bit instance
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 16'd1, 16'd0);
      end else begin
        me = q.pop_front();
        chk("sum",        sum,          me.sum);
        chk("cout",       16'(cout),    16'(me.cout));
        chk("p",          16'(p),       16'(me.p));
        chk("g",          16'(g),       16'(me.g));
        chk("ovf",        16'(ovf),     16'(me.ovf));
        chk("ready_done", 16'(ready),   16'd1);
        chk("done_cycle", 16'(cyc),     16'(me.cyc));
      end
    end
  end

  // Monitor for the 8-bit instance
  always @(negedge clk) begin
    if (done2 === 1'b1) begin
      if (q2.size() == 0) begin
        chk("unexpected_done2", 16'd1, 16'd0);
      end else begin
        me2 = q2.pop_front();
        chk("sum2",        16'(sum2),  me2.sum);
        chk("cout2",       16'(cout2), 16'(me2.cout));
        chk("p2",          16'(p2),    16'(me2.p));
        chk("g2",          16'(g2),    16'(me2.g));
        chk("ovf2",        16'(ovf2),  16'(me2.ovf));
        chk("done_cycle2", 16'(cyc),   16'(me2.cyc));
      end
    end
  end

  // Called at a negedge; start is taken on the following posedge
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic ci,
                       input logic push, input logic [15:0] es, input logic ec,
                       input logic ep, input logic eg, input logic eo);
    exp_t e;
    start = 1'b1; in1 = a; in2 = b; cin = ci;
    if (push) begin
      e.sum = es; e.cout = ec; e.p = ep; e.g = eg; e.ovf = eo;
      e.cyc = cyc + 1 + 4;
      q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    in1 = 16'($urandom); in2 = 16'($urandom); cin = 1'($urandom);
  endtask

  task automatic issue2(input logic [7:0] a, input logic [7:0] b, input logic ci,
                        input logic [7:0] es, input logic ec, input logic ep,
                        input logic eg, input logic eo);
    exp_t e;
    start2 = 1'b1; in1_2 = a; in2_2 = b; cin2 = ci;
    e.sum = 16'(es); e.cout = ec; e.p = ep; e.g = eg; e.ovf = eo;
    e.cyc = cyc + 1 + 2;
    q2.push_back(e);
    @(negedge clk);
    start2 = 1'b0;
    in1_2 = 8'($urandom); in2_2 = 8'($urandom); cin2 = 1'($urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (q.size() == 0 && q2.size() == 0) break;
      @(negedge clk);
    end
    if (q.size() != 0 || q2.size() != 0) begin
      chk("missing_done", 16'(q.size() + q2.size()), 16'd0);
      q.delete();
      q2.delete();
    end
  endtask

  task automatic wait_done();
    int seen;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin seen = 1; break; end
    end
    if (seen == 0) chk("done_timeout", 16'd0, 16'd1);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0; in1 = '0; in2 = '0; cin = 1'b0;
    start2 = 1'b0; in1_2 = '0; in2_2 = '0; cin2 = 1'b0;

    // Reset state
    #97;
    chk("rst_ready", 16'(ready), 16'd1);
    chk("rst_done",  16'(done),  16'd0);
    chk("rst_sum",   sum,        16'h0000);
    chk("rst_flags", {12'd0, cout, p, g, ovf}, 16'd0);
    #5 rst = 1'b0;
    @(negedge clk);

    // Basic add, no carries
    issue(16'h1234, 16'h4321, 1'b0, 1'b1, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();
    // Full ripple from carry-in
    issue(16'hFFFF, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
    drain();
    // All nibbles propagate, no carry-in
    issue(16'hA5C3, 16'h5A3C, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0);
    drain();
    issue(16'hA5C3, 16'h5A3C, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
    drain();

    // Positive overflow, then back-to-back negative overflow in the DONE cycle
    issue(16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_done();
    issue(16'h8000, 16'h8000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1);
    drain();

    // Start while busy is ignored
    issue(16'h00FF, 16'h0001, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("busy_ready", 16'(ready), 16'd0);
    start = 1'b1; in1 = 16'h0001; in2 = 16'h0001; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (8) @(negedge clk);

    // Asynchronous reset mid-run discards the operation
    issue(16'h1111, 16'h1111, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_ready", 16'(ready), 16'd1);
    chk("arst_done",  16'(done),  16'd0);
    chk("arst_sum",   sum,        16'h0000);
    chk("arst_flags", {12'd0, cout, p, g, ovf}, 16'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    repeat (8) @(negedge clk);
    issue(16'h000A, 16'h0005, 1'b1, 1'b1, 16'h0010, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();

    // Two-nibble instance
    issue2(8'hF0, 8'h10, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    drain();
    issue2(8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();

    repeat (8) @(negedge clk);
    chk("queues_empty", 16'(q.size() + q2.size()), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
